pe_stream_driver: RTL and testbench
===================================

Name: pe_stream_driver

Overview:
- Transmitter side of the PE valid/ready streams. Reads filter, ifmap and ipsum words from a single-port word-addressed buffer and sends them to one PE in the order the PE consumes them, then collects opsum words and writes them back to the buffer.
- Sits between the global buffer and each PE column slot. Handles one complete PE pass (all output columns) per start pulse.

Parameters:
- ADDR_W, 12, word address width of the buffer port
- DATA_W, 32, stream and buffer word width (4 packed bytes or one psum)
- CFG_W, 13, PE config width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- cfg  in  CFG_W  PE config: [12] depthwise, [11:10] rs-1, [9] mode, [8:7] p-1, [6:2] F, [1:0] q-1
- filter_base, ifmap_base, ipsum_base, opsum_base  in  ADDR_W each  region base word addresses
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last opsum write
- pe_en  out  1  one-cycle pulse to the PE
- pe_config  out  CFG_W  registered cfg, held stable while busy
- filter, ifmap, ipsum  out  DATA_W  stream data
- filter_valid, ifmap_valid, ipsum_valid  out  1  stream valid
- filter_ready, ifmap_ready, ipsum_ready  in  1  PE ready
- opsum  in  DATA_W  PE output
- opsum_valid  in  1  PE output valid
- opsum_ready  out  1  accept opsum
- rd_en  out  1  buffer read; data returns on rd_data exactly 1 cycle later
- rd_addr  out  ADDR_W
- rd_data  in  DATA_W
- wr_en  out  1  buffer write
- wr_addr  out  ADDR_W
- wr_data  out  DATA_W

Behaviour:
- Reset, synchronous: all outputs 0 and state IDLE. A reset asserted mid-pass aborts the pass immediately, with no done pulse and a flushed skid buffer. The PE must be reset together with this block.
- Derived values, latched at start:
  - p = cfg[8:7]+1, q = cfg[1:0]+1, rs = cfg[11:10]+1.
  - NPS = q if depthwise, else p.
  - NCOL = F+1 (F = 0 means one column).
  - All counters use unsigned arithmetic with widths sized for the maximum values. Address sums wrap modulo 2^ADDR_W.
- FSM states: IDLE, CFG, FILTER, IFMAP, IPSUM, OPSUM, DONE.
  - IDLE -> CFG on start. CFG drives pe_en=1 for exactly one cycle, then goes to FILTER.
  - FILTER sends p*rs words, word k read from filter_base+k, k = 0..p*rs-1.
  - IFMAP sends rs words (ifmap_base+0..rs-1) for column 0, and one word (ifmap_base+col+rs-1) for each later column. Stride is 1.
  - IPSUM sends NPS words from ipsum_base+col*NPS+k.
  - OPSUM holds opsum_ready=1. Each opsum_valid&&opsum_ready beat writes wr_addr=opsum_base+col*NPS+k and wr_data=opsum in the same cycle, using a combinational write port. After NPS beats: col+1 < NCOL -> IFMAP, else DONE.
  - DONE pulses done=1 for one cycle, then goes to IDLE.
- Send states:
  - A read is issued when the fetch count is below the word target and (buffered + in-flight) < 2.
  - Returned words enter a 2-entry FIFO whose head drives the data and valid of the active channel only. The other channels' valid stays 0 and their data is don't-care.
  - A beat is valid&&ready. The state advances in the cycle of the final beat. Zero bubbles with continuous ready: one word per cycle after the first 2-cycle fill.
  - valid, once raised, stays high with data stable until the beat completes.
  - No read is issued in a state after its target is reached; the FIFO is empty on every state exit.
- start is ignored while busy.
- Simultaneous opsum_valid and state exit: the final beat is written, and the exit happens on the same edge.

Optional Feature:
- DRV_ZERO_IPSUM_EN, when defined, adds input first_pass (1 bit), sampled at start.
  - If first_pass=1, IPSUM issues no buffer reads and sends NPS words of value 0, one per ready cycle, with valid high on state entry.
  - When the macro is undefined, the port is absent and ipsum is always read from the buffer.

Decomposition:
- Shared package pe_pkg: the state enum, CFG_W, the config field bit positions, and a function decoding cfg into p, q, rs, F and depthwise. The PE uses the same package.
- One sub-module: pe_skid_fifo (2-entry, DATA_W-wide, registered valid/data, flush input).

Test Plan:
- cfg p=1, q=1, rs=3, F=0, dense, ready always 1 -> 3 filter beats, 3 ifmap beats, 1 ipsum beat, rd_addr sequence exact; 1 opsum write to opsum_base; done 1 cycle later.
- p=2, q=4, rs=3, F=2 -> filter 6 words; ifmap words 3,1,1 at addresses +0..2, +3, +4; ipsum/opsum addresses base+col*2+k; done after 6 opsum writes.
- Depthwise q=3, rs=3, p=1 -> NPS=3; 3 ipsum and 3 opsum words per column.
- Random ready toggling (50%) on all channels -> data stable while valid&&!ready, no lost or duplicated word, max 2 outstanding reads.
- Reset asserted during IPSUM of column 1 -> next cycle all outputs 0, busy=0; a new start runs a clean pass.
- DRV_ZERO_IPSUM_EN with first_pass=1 -> no rd_en in IPSUM, ipsum=0 for NPS beats; first_pass=0 matches the default build.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared PE package: controller state encoding, config field layout and a config decoder.
// Used by both the stream driver and the PE itself.
package pe_pkg;

    localparam int CFG_W        = 13;
    localparam int CFG_DW_BIT   = 12;
    localparam int CFG_RS_LSB   = 10;
    localparam int CFG_MODE_BIT = 9;
    localparam int CFG_P_LSB    = 7;
    localparam int CFG_F_LSB    = 2;
    localparam int CFG_Q_LSB    = 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CFG    = 3'd1,
        S_FILTER = 3'd2,
        S_IFMAP  = 3'd3,
        S_IPSUM  = 3'd4,
        S_OPSUM  = 3'd5,
        S_DONE   = 3'd6
    } pe_state_e;

    typedef struct packed {
        logic       depthwise;
        logic       mode;
        logic [2:0] p;
        logic [2:0] q;
        logic [2:0] rs;
        logic [4:0] f;
    } pe_cfg_t;

    // Counts come out already biased by one so callers never see the -1 encoding.
    function automatic pe_cfg_t decode_cfg(input logic [CFG_W-1:0] c);
        pe_cfg_t r;
        r.depthwise = c[CFG_DW_BIT];
        r.mode      = c[CFG_MODE_BIT];
        r.p         = {1'b0, c[CFG_P_LSB +: 2]} + 3'd1;
        r.q         = {1'b0, c[CFG_Q_LSB +: 2]} + 3'd1;
        r.rs        = {1'b0, c[CFG_RS_LSB +: 2]} + 3'd1;
        r.f         = c[CFG_F_LSB +: 5];
        return r;
    endfunction

endpackage

// File: rtl/pe_skid_fifo.sv
// Two-entry FIFO with registered head; slot 0 is always the head word.
// flush empties it in one cycle without touching the data registers.
module pe_skid_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
        end else begin
            count_q <= count_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
        end
    end

    always_comb begin
        count_d = count_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) d0_d = push_data;
                else                 d1_d = push_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                d0_d    = d1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    d0_d = push_data;
                end else begin
                    d0_d = d1_q;
                    d1_d = push_data;
                end
            end
            default: ;
        endcase
        if (flush) count_d = '0;
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = d0_q;
    assign count     = count_q;

endmodule

// File: rtl/pe_stream_driver.sv
// Feeds one PE pass: filter, then per column ifmap/ipsum out and opsum back to the buffer.
// Optional DRV_ZERO_IPSUM_EN adds first_pass, which replaces ipsum reads with zero words.
module pe_stream_driver
    import pe_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int CFG_W  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef DRV_ZERO_IPSUM_EN
    input  logic              first_pass,
`endif
    input  logic [CFG_W-1:0]  cfg,
    input  logic [ADDR_W-1:0] filter_base,
    input  logic [ADDR_W-1:0] ifmap_base,
    input  logic [ADDR_W-1:0] ipsum_base,
    input  logic [ADDR_W-1:0] opsum_base,
    output logic              busy,
    output logic              done,
    output logic              pe_en,
    output logic [CFG_W-1:0]  pe_config,
    output logic [DATA_W-1:0] filter,
    output logic [DATA_W-1:0] ifmap,
    output logic [DATA_W-1:0] ipsum,
    output logic              filter_valid,
    output logic              ifmap_valid,
    output logic              ipsum_valid,
    input  logic              filter_ready,
    input  logic              ifmap_ready,
    input  logic              ipsum_ready,
    input  logic [DATA_W-1:0] opsum,
    input  logic              opsum_valid,
    output logic              opsum_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int CNT_W = 6;

    pe_state_e         state_q, state_d;
    logic [CFG_W-1:0]  cfg_q, cfg_d;
    logic [4:0]        col_q, col_d;
    logic [CNT_W-1:0]  fetch_q, fetch_d, beat_q, beat_d;
    logic              rd_pend_q, rd_pend_d;
    logic              zero_q, zero_d;

    pe_cfg_t           dec;
    logic              cfg_mode_unused;
    logic [2:0]        nps;
    logic [5:0]        ncol;
    logic [CNT_W-1:0]  target;
    logic              send, chan_ready, zero_mode, pop, beat, last_beat, rd_issue;
    logic [2:0]        occupancy;
    logic              head_valid;
    logic [DATA_W-1:0] head_data;
    logic [1:0]        fifo_cnt;
    logic [ADDR_W-1:0] col_nps, rd_addr_raw;

    always_comb begin
        dec             = decode_cfg(cfg_q);
        cfg_mode_unused = dec.mode;
        nps             = dec.depthwise ? dec.q : dec.p;
        ncol            = {1'b0, dec.f} + 6'd1;
    end

    pe_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (state_q == S_IDLE),
        .push      (rd_pend_q),
        .push_data (rd_data),
        .pop       (pop),
        .out_valid (head_valid),
        .out_data  (head_data),
        .count     (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cfg_q     <= '0;
            col_q     <= '0;
            fetch_q   <= '0;
            beat_q    <= '0;
            rd_pend_q <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            col_q     <= col_d;
            fetch_q   <= fetch_d;
            beat_q    <= beat_d;
            rd_pend_q <= rd_pend_d;
            zero_q    <= zero_d;
        end
    end

    // Handshake: a beat is valid && ready on the active channel; valid holds until it lands.
    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        col_d      = col_q;
        zero_d     = zero_q;
        target     = '0;
        send       = 1'b0;
        chan_ready = 1'b0;
        case (state_q)
            S_FILTER: begin
                send       = 1'b1;
                target     = {3'b0, dec.p} * {3'b0, dec.rs};
                chan_ready = filter_ready;
            end
            S_IFMAP: begin
                send       = 1'b1;
                target     = (col_q == 5'd0) ? {3'b0, dec.rs} : 6'd1;
                chan_ready = ifmap_ready;
            end
            S_IPSUM: begin
                send       = 1'b1;
                target     = {3'b0, nps};
                chan_ready = ipsum_ready;
            end
            S_OPSUM: target = {3'b0, nps};
            default: ;
        endcase

        zero_mode = (state_q == S_IPSUM) && zero_q;
        pop       = send && !zero_mode && head_valid && chan_ready;
        if (zero_mode)    beat = chan_ready;
        else if (send)    beat = pop;
        else              beat = (state_q == S_OPSUM) && opsum_valid;
        last_beat = beat && (beat_q == target - 6'd1);

        // Counting this cycle's pop keeps the read pipe full under continuous ready.
        occupancy = {1'b0, fifo_cnt} + {2'b0, rd_pend_q} - {2'b0, pop};
        rd_issue  = send && !zero_mode && (fetch_q < target) && (occupancy < 3'd2);
        rd_pend_d = rd_issue;
        fetch_d   = fetch_q + {5'b0, rd_issue};
        beat_d    = beat_q + {5'b0, beat};

        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_CFG;
                cfg_d   = cfg;
`ifdef DRV_ZERO_IPSUM_EN
                zero_d  = first_pass;
`endif
            end
            S_CFG: begin
                state_d = S_FILTER;
                col_d   = '0;
            end
            S_FILTER: if (last_beat) state_d = S_IFMAP;
            S_IFMAP:  if (last_beat) state_d = S_IPSUM;
            S_IPSUM:  if (last_beat) state_d = S_OPSUM;
            S_OPSUM: if (last_beat) begin
                if (({1'b0, col_q} + 6'd1) < ncol) begin
                    state_d = S_IFMAP;
                    col_d   = col_q + 5'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            fetch_d = '0;
            beat_d  = '0;
        end
    end

    always_comb begin
        col_nps = ADDR_W'(col_q) * ADDR_W'(nps);
        case (state_q)
            S_FILTER: rd_addr_raw = filter_base + ADDR_W'(fetch_q);
            S_IFMAP:  rd_addr_raw = (col_q == 5'd0) ? ifmap_base + ADDR_W'(fetch_q)
                                  : ifmap_base + ADDR_W'(col_q) + ADDR_W'(dec.rs) - ADDR_W'(1);
            S_IPSUM:  rd_addr_raw = ipsum_base + col_nps + ADDR_W'(fetch_q);
            default:  rd_addr_raw = '0;
        endcase

        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
        pe_en        = (state_q == S_CFG);
        pe_config    = cfg_q;
        rd_en        = rd_issue;
        rd_addr      = rd_issue ? rd_addr_raw : '0;
        filter_valid = (state_q == S_FILTER) && head_valid;
        ifmap_valid  = (state_q == S_IFMAP) && head_valid;
        ipsum_valid  = (state_q == S_IPSUM) && (zero_q || head_valid);
        filter       = (state_q == S_FILTER) ? head_data : '0;
        ifmap        = (state_q == S_IFMAP) ? head_data : '0;
        ipsum        = (state_q == S_IPSUM && !zero_q) ? head_data : '0;
        opsum_ready  = (state_q == S_OPSUM);
        wr_en        = (state_q == S_OPSUM) && opsum_valid;
        wr_addr      = wr_en ? opsum_base + col_nps + ADDR_W'(beat_q) : '0;
        wr_data      = wr_en ? opsum : '0;
    end

endmodule

// File: tb/tb_pe_stream_driver.sv
// Bench for pe_stream_driver: buffer model, randomized PE handshakes and an event-order model.
// Define DRV_ZERO_IPSUM_EN for both RTL and bench to exercise the zero-ipsum path.
module tb_pe_stream_driver;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int CFG_W  = 13;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CFG_W-1:0]  cfg = '0;
    logic [ADDR_W-1:0] filter_base = '0, ifmap_base = '0, ipsum_base = '0, opsum_base = '0;
    logic              busy, done, pe_en;
    logic [CFG_W-1:0]  pe_config;
    logic [DATA_W-1:0] filter, ifmap, ipsum;
    logic              filter_valid, ifmap_valid, ipsum_valid;
    logic              filter_ready = 1'b0, ifmap_ready = 1'b0, ipsum_ready = 1'b0;
    logic [DATA_W-1:0] opsum = '0;
    logic              opsum_valid = 1'b0;
    logic              opsum_ready;
    logic              rd_en, wr_en;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic [DATA_W-1:0] wr_data;
`ifdef DRV_ZERO_IPSUM_EN
    logic              first_pass = 1'b0;
`endif

    always #5 clk = ~clk;

    pe_stream_driver dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef DRV_ZERO_IPSUM_EN
        .first_pass(first_pass),
`endif
        .cfg(cfg), .filter_base(filter_base), .ifmap_base(ifmap_base),
        .ipsum_base(ipsum_base), .opsum_base(opsum_base),
        .busy(busy), .done(done), .pe_en(pe_en), .pe_config(pe_config),
        .filter(filter), .ifmap(ifmap), .ipsum(ipsum),
        .filter_valid(filter_valid), .ifmap_valid(ifmap_valid), .ipsum_valid(ipsum_valid),
        .filter_ready(filter_ready), .ifmap_ready(ifmap_ready), .ipsum_ready(ipsum_ready),
        .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    // Buffer: one-cycle read latency, garbage on idle cycles.
    logic [DATA_W-1:0] mem [0:4095];
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : $urandom();

    int   checks = 0;
    int   failures = 0;
    int   rdy_pct = 100;
    logic zero_cur = 1'b0;
    logic mon_en = 1'b0;

    // kind: 0 filter, 1 ifmap, 2 ipsum (val = data), 3 opsum write (val = address)
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] val;
    } ev_t;
    ev_t               exp_seq[$];
    logic [ADDR_W-1:0] exp_rd_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        filter_ready = (int'($urandom_range(0, 99)) < rdy_pct);
        ifmap_ready  = (int'($urandom_range(0, 99)) < rdy_pct);
        ipsum_ready  = (int'($urandom_range(0, 99)) < rdy_pct);
        opsum_valid  = (int'($urandom_range(0, 99)) < rdy_pct);
        opsum        = $urandom();
    end

    task automatic push_ev(input logic [1:0] k, input logic [31:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_seq.push_back(e);
    endtask

    task automatic push_rd(input logic [1:0] k, input logic [ADDR_W-1:0] a);
        exp_rd_q.push_back(a);
        push_ev(k, mem[a]);
    endtask

    // Whole-pass expectation straight from the stream ordering rules.
    task automatic build_model(input logic [CFG_W-1:0] c, input logic [ADDR_W-1:0] fb, ib, pb, ob,
                               input logic fp);
        int p, q, rs, f, nps;
        p   = int'(c[8:7]) + 1;
        q   = int'(c[1:0]) + 1;
        rs  = int'(c[11:10]) + 1;
        f   = int'(c[6:2]);
        nps = c[12] ? q : p;
        exp_seq.delete();
        exp_rd_q.delete();
        for (int k = 0; k < p * rs; k++) push_rd(2'd0, fb + 12'(k));
        for (int col = 0; col <= f; col++) begin
            if (col == 0) for (int k = 0; k < rs; k++) push_rd(2'd1, ib + 12'(k));
            else push_rd(2'd1, ib + 12'(col + rs - 1));
            for (int k = 0; k < nps; k++) begin
                if (fp) push_ev(2'd2, 32'd0);
                else    push_rd(2'd2, pb + 12'(col * nps + k));
            end
            for (int k = 0; k < nps; k++) push_ev(2'd3, 32'(ob + 12'(col * nps + k)));
        end
    endtask

    int          cyc = 0, occ = 0, last_wr = 0;
    int          done_tot = 0, pe_en_tot = 0, wr_tot = 0;
    logic [2:0]  stall = '0;
    logic [31:0] held [3];

    always @(negedge clk) begin : mon
        logic [2:0]  v, r;
        logic [31:0] d [3];
        ev_t         e;
        cyc++;
        if (!mon_en) begin
            occ   = 0;
            stall = '0;
        end else begin
            v = {ipsum_valid, ifmap_valid, filter_valid};
            r = {ipsum_ready, ifmap_ready, filter_ready};
            d[0] = filter; d[1] = ifmap; d[2] = ipsum;
            if (rd_en) begin
                if (exp_rd_q.size() == 0) chk("rd_extra", 64'(rd_en), 64'(0));
                else chk("rd_addr", 64'(rd_addr), 64'(exp_rd_q.pop_front()));
                occ++;
            end
            for (int ch = 0; ch < 3; ch++) begin
                if (stall[ch]) begin
                    chk("hold_valid", 64'(v[ch]), 64'(1));
                    chk("hold_data", 64'(d[ch]), 64'(held[ch]));
                end
                if (v[ch] && r[ch]) begin
                    if (exp_seq.size() == 0) chk("send_extra", 64'(v[ch]), 64'(0));
                    else begin
                        e = exp_seq.pop_front();
                        chk("send_kind", 64'(ch), 64'(e.kind));
                        chk("send_data", 64'(d[ch]), 64'(e.val));
                    end
                    if (!(ch == 2 && zero_cur)) occ--;
                end
                stall[ch] = v[ch] && !r[ch];
                held[ch]  = d[ch];
            end
            if (rd_en) chk("outstanding", 64'(occ > 2), 64'(0));
            if (opsum_ready) begin
                if (exp_seq.size() == 0) chk("opsum_ready_extra", 64'(opsum_ready), 64'(0));
                else chk("opsum_ready_order", 64'(exp_seq[0].kind), 64'(3));
            end
            if (opsum_valid && opsum_ready) begin
                chk("wr_en", 64'(wr_en), 64'(1));
                if (exp_seq.size() != 0 && exp_seq[0].kind == 2'd3) begin
                    e = exp_seq.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(e.val[11:0]));
                    chk("wr_data", 64'(wr_data), 64'(opsum));
                end
                last_wr = cyc;
                wr_tot++;
            end else if (wr_en) begin
                chk("wr_spurious", 64'(wr_en), 64'(0));
            end
            if (pe_en) pe_en_tot++;
            if (done) begin
                done_tot++;
                chk("done_latency", 64'(cyc), 64'(last_wr + 1));
            end
        end
    end

    int done_base, pe_base, wr_base;

    task automatic chk_outputs_zero();
        chk("rst_ctl", 64'({busy, done, pe_en, pe_config, filter_valid, ifmap_valid, ipsum_valid,
                            opsum_ready, rd_en, wr_en}), 64'(0));
        chk("rst_addr", 64'({rd_addr, wr_addr}), 64'(0));
        chk("rst_data_a", 64'({filter, ifmap}), 64'(0));
        chk("rst_data_b", 64'({ipsum, wr_data}), 64'(0));
    endtask

    task automatic start_pass(input logic [CFG_W-1:0] c, input logic [ADDR_W-1:0] fb, ib, pb, ob,
                              input int pct, input logic fp);
        build_model(c, fb, ib, pb, ob, fp);
        cfg = c; filter_base = fb; ifmap_base = ib; ipsum_base = pb; opsum_base = ob;
        rdy_pct  = pct;
        zero_cur = fp;
`ifdef DRV_ZERO_IPSUM_EN
        first_pass = fp;
`endif
        done_base = done_tot; pe_base = pe_en_tot; wr_base = wr_tot;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_on_start", 64'(busy), 64'(1));
        chk("pe_config", 64'(pe_config), 64'(c));
    endtask

    task automatic finish_pass();
        int n = 0;
        while (done_tot == done_base && n < 6000) begin
            @(posedge clk);
            n++;
        end
        chk("done_timeout", 64'(n < 6000), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        chk("done_pulses", 64'(done_tot - done_base), 64'(1));
        chk("pe_en_pulses", 64'(pe_en_tot - pe_base), 64'(1));
        chk("seq_left", 64'(exp_seq.size()), 64'(0));
        chk("rd_left", 64'(exp_rd_q.size()), 64'(0));
        chk("busy_idle", 64'(busy), 64'(0));
    endtask

    localparam logic [CFG_W-1:0] CFG_A = 13'((2 << 10));
    localparam logic [CFG_W-1:0] CFG_B = 13'((2 << 10) | (1 << 7) | (2 << 2) | 3);
    localparam logic [CFG_W-1:0] CFG_C = 13'((1 << 12) | (2 << 10) | (1 << 2) | 2);

    initial begin
        logic [CFG_W-1:0] c;
        int n;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom();

        repeat (3) @(posedge clk);
        #1 chk_outputs_zero();
        rst = 1'b0;
        mon_en = 1'b1;

        start_pass(CFG_A, 12'h100, 12'h200, 12'h300, 12'h400, 100, 1'b0);
        finish_pass();

        // A second start mid-pass with a different cfg must be ignored.
        start_pass(CFG_B, 12'h010, 12'h020, 12'h030, 12'h040, 100, 1'b0);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; cfg = 13'h1fff;
        @(posedge clk);
        #1 start = 1'b0;
        chk("pe_config_hold", 64'(pe_config), 64'(CFG_B));
        finish_pass();

        start_pass(CFG_C, 12'h500, 12'h600, 12'h700, 12'h800, 100, 1'b0);
        finish_pass();

        for (int i = 0; i < 4; i++) begin
            c = {1'($urandom()), 2'($urandom()), 1'($urandom()), 2'($urandom()),
                 5'($urandom_range(0, 5)), 2'($urandom())};
            start_pass(c, (i == 0) ? 12'hffd : 12'($urandom()), 12'($urandom()),
                       12'($urandom()), (i == 1) ? 12'hffe : 12'($urandom()), 50, 1'b0);
            finish_pass();
        end

        // Abort during column 1 ipsum, then confirm a clean pass follows.
        start_pass(CFG_B, 12'h0a0, 12'h0b0, 12'h0c0, 12'h0d0, 50, 1'b0);
        n = 0;
        while (!(ipsum_valid && (wr_tot - wr_base) >= 2) && n < 6000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_col1_ipsum", 64'(n < 6000), 64'(1));
        rst = 1'b1;
        mon_en = 1'b0;
        @(posedge clk);
        #1 chk_outputs_zero();
        rst = 1'b0;
        mon_en = 1'b1;
        start_pass(CFG_B, 12'h0a0, 12'h0b0, 12'h0c0, 12'h0d0, 50, 1'b0);
        finish_pass();

`ifdef DRV_ZERO_IPSUM_EN
        start_pass(CFG_B, 12'h111, 12'h222, 12'h333, 12'h444, 50, 1'b1);
        finish_pass();
        start_pass(CFG_C, 12'h111, 12'h222, 12'h333, 12'h444, 100, 1'b1);
        finish_pass();
        start_pass(CFG_B, 12'h111, 12'h222, 12'h333, 12'h444, 50, 1'b0);
        finish_pass();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
